serial_addition: RTL and testbench

SERIAL_ADDITION -- requirements
Module: serial_addition

---
 rtl/serial_addition_pkg.sv | 18 +
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_addition.sv | 127 ++++++++++++
 tb/tb_serial_addition.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_addition_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_addition_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder used for the per-cycle serial add.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addition.sv
// Bit-serial adder: one bit pair per cycle, LSB first, WIDTH+1-bit registered result.
// Define SERIAL_ADDITION_OVF_EN to enable the registered two's-complement overflow flag.
module serial_addition
    import serial_addition_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   Y,
    output logic             ovf
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Holds the WIDTH-1 sum bits already produced; the last one goes straight into Y.
    logic [WIDTH-2:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_y;
    logic             w_s;
    logic             w_cout;
    logic             w_last;

    full_adder_bit u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_last = (r_cnt == CW'(WIDTH - 1));
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sum   <= {w_s, r_sum[WIDTH-2:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_y <= {w_cout, w_s, r_sum};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDITION_OVF_EN
    logic r_ovf;
    logic w_ovf_last;

    // On the last RUN cycle r_a[0]/r_b[0] are the operand sign bits and w_s is the sum sign.
    assign w_ovf_last = (r_a[0] == r_b[0]) && (w_s != r_a[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_ovf_last;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign Y    = r_y;

endmodule

// File: tb/tb_serial_addition.sv
// Directed and random checks of serial_addition timing, results and reset behaviour.
module tb_serial_addition;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W:0]   Y;
    logic         ovf;

    int n_checks;
    int n_fail;
    logic [W:0] prev_y;
    logic       prev_ovf;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   y;
        logic         ovf_en;
    } vec_t;

    serial_addition #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Y     (Y),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic exp_ovf(input logic ovf_en);
`ifdef SERIAL_ADDITION_OVF_EN
        return ovf_en;
`else
        return 1'b0 & ovf_en;
`endif
    endfunction

    // Called in an IDLE cycle; returns in the IDLE cycle after done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] ey, input logic eo);
        start = 1'b1;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        A     = ~a;
        B     = b ^ 4'b0110;
        for (int i = 1; i <= int'(W); i++) begin
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            check("y_hold_run", 32'(Y), 32'(prev_y));
            check("ovf_hold_run", 32'(ovf), 32'(prev_ovf));
            tick();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("y_result", 32'(Y), 32'(ey));
        check("ovf_result", 32'(ovf), 32'(eo));
        tick();
        check("done_clear", 32'(done), 32'd0);
        prev_y   = ey;
        prev_ovf = eo;
    endtask

    initial begin
        vec_t vecs[10];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   ry;
        logic         ro;

        vecs[0] = '{a: 4'd5,  b: 4'd3,  y: 5'b01000, ovf_en: 1'b1};
        vecs[1] = '{a: 4'd15, b: 4'd15, y: 5'b11110, ovf_en: 1'b0};
        vecs[2] = '{a: 4'd7,  b: 4'd1,  y: 5'b01000, ovf_en: 1'b1};
        vecs[3] = '{a: 4'd11, b: 4'd5,  y: 5'b10000, ovf_en: 1'b0};
        vecs[4] = '{a: 4'd0,  b: 4'd0,  y: 5'b00000, ovf_en: 1'b0};
        vecs[5] = '{a: 4'd8,  b: 4'd8,  y: 5'b10000, ovf_en: 1'b1};
        vecs[6] = '{a: 4'd9,  b: 4'd6,  y: 5'b01111, ovf_en: 1'b0};
        vecs[7] = '{a: 4'd10, b: 4'd13, y: 5'b10111, ovf_en: 1'b1};
        vecs[8] = '{a: 4'd2,  b: 4'd5,  y: 5'b00111, ovf_en: 1'b0};
        vecs[9] = '{a: 4'd12, b: 4'd3,  y: 5'b01111, ovf_en: 1'b0};

        n_checks = 0;
        n_fail   = 0;
        prev_y   = '0;
        prev_ovf = 1'b0;

        // Reset with start asserted: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        A     = 4'd5;
        B     = 4'd3;
        @(negedge clk);
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(Y), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].y, exp_ovf(vecs[i].ovf_en));
        end

        // start held high through RUN/DONE with operands changed after capture.
        start = 1'b1;
        A     = 4'd11;
        B     = 4'd5;
        tick();
        A = 4'd2;
        B = 4'd3;
        for (int i = 1; i <= int'(W); i++) begin
            check("hold_busy1", 32'(busy), 32'd1);
            check("hold_y1", 32'(Y), 32'(prev_y));
            tick();
        end
        check("hold_done1", 32'(done), 32'd1);
        check("hold_res1", 32'(Y), 32'b10000);
        check("hold_ovf1", 32'(ovf), 32'd0);
        tick();
        check("hold_idle_busy", 32'(busy), 32'd0);
        check("hold_idle_done", 32'(done), 32'd0);
        check("hold_idle_y", 32'(Y), 32'b10000);
        tick();
        start = 1'b0;
        for (int i = 1; i <= int'(W); i++) begin
            check("hold_busy2", 32'(busy), 32'd1);
            check("hold_y2", 32'(Y), 32'b10000);
            tick();
        end
        check("hold_done2", 32'(done), 32'd1);
        check("hold_res2", 32'(Y), 32'b00101);
        check("hold_ovf2", 32'(ovf), 32'd0);
        tick();
        prev_y   = 5'b00101;
        prev_ovf = 1'b0;

        // Reset in RUN cycle 2 abandons the operation.
        start = 1'b1;
        A     = 4'd6;
        B     = 4'd7;
        tick();
        start = 1'b0;
        tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_y", 32'(Y), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_y_zero", 32'(Y), 32'd0);
            tick();
        end
        prev_y   = '0;
        prev_ovf = 1'b0;
        do_op(4'd9, 4'd6, 5'b01111, 1'b0);

        // Random operands against an integer reference model.
        for (int n = 0; n < 200; n++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ry = {1'b0, ra} + {1'b0, rb};
            ro = exp_ovf((ra[W-1] == rb[W-1]) && (ry[W-1] != ra[W-1]));
            do_op(ra, rb, ry, ro);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
